// File: rtl/mpu_imul_if.sv
// -----------------------------------------------------------------------------
// mpu_imul_if
//   Handshake/operand/result bundle between the MPU instruction decoder
//   (master side) and the scalar-times-matrix engine (slave side).
//
//   start        master -> slave  request a new operation (taken while idle)
//   abort        master -> slave  cancel the operation in flight
//   matrix_a     master -> slave  5x5 int8 operand, element k=i+5*j at [8k+7:8k]
//   factor       master -> slave  int8 scalar operand
//   busy         slave -> master  engine is sequencing elements
//   done         slave -> master  one-cycle pulse when the product is complete
//   result_valid slave -> master  result holds a complete product
//   result       slave -> master  5x5 int8 product, same layout as matrix_a
//   overflow     slave -> master  some product of this operation left [-128,127]
// -----------------------------------------------------------------------------
interface mpu_imul_if;
   logic         start;
   logic         abort;
   logic [199:0] matrix_a;
   logic [7:0]   factor;
   logic         busy;
   logic         done;
   logic         result_valid;
   logic [199:0] result;
   logic         overflow;

   modport master (
      output start, abort, matrix_a, factor,
      input  busy, done, result_valid, result, overflow
   );

   modport slave (
      input  start, abort, matrix_a, factor,
      output busy, done, result_valid, result, overflow
   );
endinterface

// File: rtl/mpu_imul_sequencer.sv
// -----------------------------------------------------------------------------
// mpu_imul_sequencer
//   Multiplies a 5x5 matrix of signed 8-bit elements by a signed 8-bit factor,
//   LANES elements per clock, using shared 8x8 multipliers. Operands are
//   captured when start is taken in IDLE; the elements are then walked in
//   index order and done pulses for one cycle once the last one is written.
//
//   Parameters
//     LANES     elements multiplied per cycle (1..25)
//     SATURATE  1 = clamp each product to [-128,127], 0 = keep the low byte
//
//   Ports
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    mpu_imul_if.slave: start/abort/matrix_a/factor in,
//            busy/done/result_valid/result/overflow out
// -----------------------------------------------------------------------------
module mpu_imul_sequencer #(
   parameter int LANES    = 1,
   parameter int SATURATE = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   mpu_imul_if.slave   bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [5:0] N_ELEM   = 6'd25;
   localparam logic [5:0] LANE_STEP = 6'(LANES);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [0:0]   state_q,        state_d;
   logic [5:0]   idx_q,          idx_d;
   logic [199:0] a_q,            a_d;
   logic [7:0]   factor_q,       factor_d;
   logic [199:0] result_q,       result_d;
   logic         done_q,         done_d;
   logic         result_valid_q, result_valid_d;
   logic         overflow_q,     overflow_d;

   // ---------------------------------------------------------------------
   // Lanes: lane n handles element idx+n of the current beat
   // ---------------------------------------------------------------------
   logic [LANES-1:0] lane_en;
   logic [LANES-1:0] lane_ovf;
   logic [5:0]       lane_idx [LANES];
   logic [7:0]       lane_res [LANES];

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [5:0]         sel_idx;
         logic signed [7:0]  a_el;
         logic signed [15:0] a_ext;
         logic signed [15:0] f_ext;
         logic signed [15:0] prod;

         assign lane_idx[gi] = idx_q + 6'(gi);
         // On a partial last beat the upper lanes fall past element 24.
         assign lane_en[gi]  = (lane_idx[gi] < N_ELEM);
         // Unused lanes read element 0 so the select never leaves the vector.
         assign sel_idx      = lane_en[gi] ? lane_idx[gi] : 6'd0;
         assign a_el         = a_q[{sel_idx, 3'b000} +: 8];

         // 8x8 signed product; the full value always fits in 16 bits.
         assign a_ext = {{8{a_el[7]}}, a_el};
         assign f_ext = {{8{factor_q[7]}}, factor_q};
         assign prod  = a_ext * f_ext;

         assign lane_ovf[gi] = (prod > 16'sd127) || (prod < -16'sd128);

         if (SATURATE != 0) begin : g_sat
            assign lane_res[gi] = lane_ovf[gi] ? (prod[15] ? 8'h80 : 8'h7F)
                                               : prod[7:0];
         end else begin : g_wrap
            assign lane_res[gi] = prod[7:0];
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Merge the enabled lanes into the result and the overflow flag
   // ---------------------------------------------------------------------
   logic [199:0] beat_result;
   logic         beat_ovf;

   always_comb begin
      beat_result = result_q;
      beat_ovf    = 1'b0;
      for (int n = 0; n < LANES; n++) begin
         if (lane_en[n]) begin
            beat_result[{lane_idx[n], 3'b000} +: 8] = lane_res[n];
            beat_ovf = beat_ovf | lane_ovf[n];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      a_d            = a_q;
      factor_d       = factor_q;
      result_d       = result_q;
      done_d         = 1'b0;
      result_valid_d = result_valid_q;
      overflow_d     = overflow_q;

      case (state_q)
         ST_IDLE: begin
            // abort is meaningless here, so start always wins.
            if (bus.start) begin
               state_d        = ST_RUN;
               a_d            = bus.matrix_a;
               factor_d       = bus.factor;
               idx_d          = 6'd0;
               overflow_d     = 1'b0;
               result_valid_d = 1'b0;
            end
         end

         ST_RUN: begin
            if (bus.abort) begin
               // Abort beats completion even on the final beat; the partly
               // written result is left behind and never marked valid.
               state_d = ST_IDLE;
               idx_d   = 6'd0;
            end else begin
               result_d   = beat_result;
               overflow_d = overflow_q | beat_ovf;
               if (idx_q + LANE_STEP >= N_ELEM) begin
                  state_d        = ST_IDLE;
                  idx_d          = 6'd0;
                  done_d         = 1'b1;
                  result_valid_d = 1'b1;
               end else begin
                  idx_d = idx_q + LANE_STEP;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = 6'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= 6'd0;
         a_q            <= '0;
         factor_q       <= '0;
         result_q       <= '0;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         a_q            <= a_d;
         factor_q       <= factor_d;
         result_q       <= result_d;
         done_q         <= done_d;
         result_valid_q <= result_valid_d;
         overflow_q     <= overflow_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.busy         = (state_q == ST_RUN);
   assign bus.done         = done_q;
   assign bus.result_valid = result_valid_q;
   assign bus.result       = result_q;
   assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_mpu_imul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mpu_imul_sequencer
//   Three engines (LANES=1/SAT=0, LANES=5/SAT=1, LANES=7/SAT=0) share one
//   stimulus stream. A per-engine transaction model (accept / count down
//   ceil(25/LANES) edges / publish) predicts busy, done, result_valid and,
//   while valid, the result matrix and overflow flag.
// -----------------------------------------------------------------------------
module tb_mpu_imul_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         start;
   logic         abort;
   logic [199:0] matrix_a;
   logic [7:0]   factor;

   mpu_imul_if if1 ();
   mpu_imul_if if5 ();
   mpu_imul_if if7 ();

   assign if1.start = start;  assign if1.abort = abort;
   assign if1.matrix_a = matrix_a;  assign if1.factor = factor;
   assign if5.start = start;  assign if5.abort = abort;
   assign if5.matrix_a = matrix_a;  assign if5.factor = factor;
   assign if7.start = start;  assign if7.abort = abort;
   assign if7.matrix_a = matrix_a;  assign if7.factor = factor;

   mpu_imul_sequencer #(.LANES(1), .SATURATE(0)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   mpu_imul_sequencer #(.LANES(5), .SATURATE(1)) u_l5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));
   mpu_imul_sequencer #(.LANES(7), .SATURATE(0)) u_l7 (.clk(clk), .rst_n(rst_n), .bus(if7.slave));

   // Observed outputs, indexed by engine
   logic [2:0]   o_ctl [3];
   logic [199:0] o_res [3];
   logic         o_ovf [3];
   assign o_ctl[0] = {if1.busy, if1.done, if1.result_valid};
   assign o_ctl[1] = {if5.busy, if5.done, if5.result_valid};
   assign o_ctl[2] = {if7.busy, if7.done, if7.result_valid};
   assign o_res[0] = if1.result;  assign o_ovf[0] = if1.overflow;
   assign o_res[1] = if5.result;  assign o_ovf[1] = if5.overflow;
   assign o_res[2] = if7.result;  assign o_ovf[2] = if7.overflow;

   int lanes_c [3] = '{1, 5, 7};
   bit sat_c   [3] = '{1'b0, 1'b1, 1'b0};

   // Transaction model
   bit           m_busy [3];
   bit           m_done [3];
   bit           m_rv   [3];
   int           m_cnt  [3];
   logic [199:0] m_res  [3];
   bit           m_ovf  [3];
   logic [199:0] p_res  [3];
   bit           p_ovf  [3];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Element-wise reference: exact integer product, then wrap or clamp.
   function automatic void ref_op(input logic [199:0] a, input logic [7:0] f,
                                  input bit sat, output logic [199:0] r, output bit ov);
      logic signed [7:0] ak;
      logic signed [7:0] fs;
      int p;
      int e;
      r  = '0;
      ov = 1'b0;
      fs = f;
      for (int k = 0; k < 25; k++) begin
         ak = a[k*8 +: 8];
         p  = int'(ak) * int'(fs);
         e  = p;
         if (sat) begin
            if (p > 127) e = 127;
            else if (p < -128) e = -128;
         end
         r[k*8 +: 8] = 8'(e);
         if (p > 127 || p < -128) ov = 1'b1;
      end
   endfunction

   function automatic logic [199:0] rand200();
      logic [223:0] w;
      for (int i = 0; i < 7; i++) w[i*32 +: 32] = $urandom;
      return w[199:0];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_busy[d] = 0; m_done[d] = 0; m_rv[d] = 0; m_cnt[d] = 0;
         m_res[d] = '0; m_ovf[d] = 0; p_res[d] = '0; p_ovf[d] = 0;
      end
   endtask

   // Drive one cycle of inputs, take the edge, advance the model, sample at +1.
   task automatic step(input logic s, input logic ab, input logic [199:0] a, input logic [7:0] f);
      start = s; abort = ab; matrix_a = a; factor = f;
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         m_done[d] = 0;
         if (!m_busy[d]) begin
            if (s) begin
               m_busy[d] = 1;
               m_rv[d]   = 0;
               m_cnt[d]  = (25 + lanes_c[d] - 1) / lanes_c[d];
               ref_op(a, f, sat_c[d], p_res[d], p_ovf[d]);
            end
         end else if (ab) begin
            m_busy[d] = 0;
            m_rv[d]   = 0;
         end else begin
            m_cnt[d]--;
            if (m_cnt[d] == 0) begin
               m_busy[d] = 0; m_done[d] = 1; m_rv[d] = 1;
               m_res[d] = p_res[d]; m_ovf[d] = p_ovf[d];
            end
         end
      end
      #1;
      cyc++;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0; start = 0; abort = 0; matrix_a = '0; factor = '0;
      model_reset();
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if ({o_ctl[d], o_ovf[d], o_res[d]} !== '0) begin
            n_fail++;
            $display("FAIL reset dut%0d got ctl=%b ovf=%b res=%h expected all zero", d, o_ctl[d], o_ovf[d], o_res[d]);
         end
      end
      #3 rst_n = 1'b1;
      $display("[TB] reset checked");
   endtask

   // Three fixed operand patterns; operands are scrambled while busy.
   task automatic test_patterns();
      logic [199:0] a;
      logic [7:0]   f;
      logic [199:0] ew;
      logic [7:0]   wrap_tab [3] = '{8'h00, 8'hC8, 8'hF1};
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 25; k++) begin
            a[k*8 +: 8]  = (p == 0) ? 8'(k + 1) : (p == 1) ? 8'd100 : 8'hFD;
            ew[k*8 +: 8] = (p == 0) ? 8'(2*k + 2) : wrap_tab[p];
         end
         f = (p == 2) ? 8'd5 : 8'd2;
         for (int c = 0; c < 28; c++) begin
            if (c == 0) step(1'b1, 1'b0, a, f);
            else        step(1'b0, 1'b0, rand200(), 8'($urandom));
            for (int d = 0; d < 3; d++) begin
               n_tests++;
               if (o_ctl[d] !== {m_busy[d], m_done[d], m_rv[d]}) begin
                  n_fail++;
                  $display("FAIL patterns_ctl pat%0d dut%0d cyc%0d busy/done/valid got %b expected %b", p, d, cyc, o_ctl[d], {m_busy[d], m_done[d], m_rv[d]});
               end
               if (m_rv[d]) begin
                  n_tests++;
                  if ({o_ovf[d], o_res[d]} !== {m_ovf[d], m_res[d]}) begin
                     n_fail++;
                     $display("FAIL patterns_res pat%0d dut%0d cyc%0d got ovf=%b res=%h expected ovf=%b res=%h", p, d, cyc, o_ovf[d], o_res[d], m_ovf[d], m_res[d]);
                  end
               end
            end
         end
         // Worked examples: LANES=1 wrap engine and the saturating engine.
         n_tests++;
         if ({o_ovf[0], o_res[0]} !== {(p == 1), ew}) begin
            n_fail++;
            $display("FAIL patterns_example pat%0d wrap got ovf=%b res=%h expected ovf=%b res=%h", p, o_ovf[0], o_res[0], (p == 1), ew);
         end
         if (p == 1) begin
            n_tests++;
            if ({o_ovf[1], o_res[1]} !== {1'b1, {25{8'h7F}}}) begin
               n_fail++;
               $display("FAIL patterns_sat got ovf=%b res=%h expected ovf=1 res=all 7f", o_ovf[1], o_res[1]);
            end
         end
         $display("[TB] pattern %0d done at cycle %0d", p, cyc);
      end
   endtask

   // New start in the very cycle the LANES=5 engine shows done.
   task automatic test_back_to_back();
      int guard = 0;
      int dones = 0;
      step(1'b1, 1'b0, rand200(), 8'($urandom));
      while (!m_done[1] && guard < 10) begin
         step(1'b0, 1'b0, rand200(), 8'($urandom));
         guard++;
      end
      n_tests++;
      if (o_ctl[1][1] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first_done got done=%b expected 1 (after %0d cycles)", o_ctl[1][1], guard);
      end
      for (int c = 0; c < 30; c++) begin
         if (c == 0) step(1'b1, 1'b0, rand200(), 8'($urandom));
         else        step(1'b0, 1'b0, rand200(), 8'($urandom));
         if (o_ctl[1][1] === 1'b1) dones++;
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (o_ctl[d] !== {m_busy[d], m_done[d], m_rv[d]}) begin
               n_fail++;
               $display("FAIL b2b_ctl dut%0d cyc%0d busy/done/valid got %b expected %b", d, cyc, o_ctl[d], {m_busy[d], m_done[d], m_rv[d]});
            end
            if (m_rv[d]) begin
               n_tests++;
               if ({o_ovf[d], o_res[d]} !== {m_ovf[d], m_res[d]}) begin
                  n_fail++;
                  $display("FAIL b2b_res dut%0d cyc%0d got ovf=%b res=%h expected ovf=%b res=%h", d, cyc, o_ovf[d], o_res[d], m_ovf[d], m_res[d]);
               end
            end
         end
      end
      n_tests++;
      if (dones != 1) begin
         n_fail++;
         $display("FAIL b2b_second_done got %0d done pulses expected 1", dones);
      end
      $display("[TB] back-to-back done at cycle %0d", cyc);
   endtask

   // start with new operands while busy must be ignored.
   task automatic test_busy_start();
      int dones = 0;
      for (int c = 0; c < 30; c++) begin
         step((c == 0 || c == 3), 1'b0, rand200(), 8'($urandom));
         if (o_ctl[0][1] === 1'b1) dones++;
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (o_ctl[d] !== {m_busy[d], m_done[d], m_rv[d]}) begin
               n_fail++;
               $display("FAIL busy_start_ctl dut%0d cyc%0d busy/done/valid got %b expected %b", d, cyc, o_ctl[d], {m_busy[d], m_done[d], m_rv[d]});
            end
            if (m_rv[d]) begin
               n_tests++;
               if ({o_ovf[d], o_res[d]} !== {m_ovf[d], m_res[d]}) begin
                  n_fail++;
                  $display("FAIL busy_start_res dut%0d cyc%0d got ovf=%b res=%h expected ovf=%b res=%h", d, cyc, o_ovf[d], o_res[d], m_ovf[d], m_res[d]);
               end
            end
         end
      end
      n_tests++;
      if (dones != 1) begin
         n_fail++;
         $display("FAIL busy_start_dones got %0d done pulses expected 1", dones);
      end
      $display("[TB] busy start done at cycle %0d", cyc);
   endtask

   // Abort on edge 10, then abort+start together while idle.
   task automatic test_abort();
      int dones = 0;
      for (int c = 0; c < 60; c++) begin
         if (c == 0)       step(1'b1, 1'b0, rand200(), 8'($urandom));
         else if (c == 10) step(1'b0, 1'b1, rand200(), 8'($urandom));
         else if (c == 30) step(1'b1, 1'b1, rand200(), 8'($urandom));
         else              step(1'b0, 1'b0, rand200(), 8'($urandom));
         if (c < 30 && o_ctl[0][1] === 1'b1) dones++;
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (o_ctl[d] !== {m_busy[d], m_done[d], m_rv[d]}) begin
               n_fail++;
               $display("FAIL abort_ctl dut%0d cyc%0d busy/done/valid got %b expected %b", d, cyc, o_ctl[d], {m_busy[d], m_done[d], m_rv[d]});
            end
            if (m_rv[d]) begin
               n_tests++;
               if ({o_ovf[d], o_res[d]} !== {m_ovf[d], m_res[d]}) begin
                  n_fail++;
                  $display("FAIL abort_res dut%0d cyc%0d got ovf=%b res=%h expected ovf=%b res=%h", d, cyc, o_ovf[d], o_res[d], m_ovf[d], m_res[d]);
               end
            end
         end
      end
      n_tests++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL abort_no_done got %0d done pulses expected 0", dones);
      end
      $display("[TB] abort done at cycle %0d", cyc);
   endtask

   // Asynchronous reset in the middle of an operation.
   task automatic test_async_reset();
      for (int c = 0; c < 12; c++)
         step((c == 0), 1'b0, rand200(), 8'($urandom));
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if ({o_ctl[d], o_ovf[d], o_res[d]} !== '0) begin
            n_fail++;
            $display("FAIL async_reset dut%0d got ctl=%b ovf=%b res=%h expected all zero", d, o_ctl[d], o_ovf[d], o_res[d]);
         end
      end
      model_reset();
      #3 rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         step(1'b0, 1'b0, rand200(), 8'($urandom));
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (o_ctl[d] !== {m_busy[d], m_done[d], m_rv[d]}) begin
               n_fail++;
               $display("FAIL async_reset_after dut%0d cyc%0d busy/done/valid got %b expected %b", d, cyc, o_ctl[d], {m_busy[d], m_done[d], m_rv[d]});
            end
         end
      end
      $display("[TB] async reset done at cycle %0d", cyc);
   endtask

   // Random starts, aborts and operands.
   task automatic test_random();
      for (int c = 0; c < 200; c++) begin
         step(($urandom % 4) == 0, ($urandom % 16) == 0, rand200(), 8'($urandom));
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (o_ctl[d] !== {m_busy[d], m_done[d], m_rv[d]}) begin
               n_fail++;
               $display("FAIL random_ctl dut%0d cyc%0d busy/done/valid got %b expected %b", d, cyc, o_ctl[d], {m_busy[d], m_done[d], m_rv[d]});
            end
            if (m_rv[d]) begin
               n_tests++;
               if ({o_ovf[d], o_res[d]} !== {m_ovf[d], m_res[d]}) begin
                  n_fail++;
                  $display("FAIL random_res dut%0d cyc%0d got ovf=%b res=%h expected ovf=%b res=%h", d, cyc, o_ovf[d], o_res[d], m_ovf[d], m_res[d]);
               end
            end
         end
      end
      $display("[TB] random done at cycle %0d", cyc);
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_back_to_back();
      step(1'b0, 1'b0, '0, '0);
      for (int c = 0; c < 26; c++) step(1'b0, 1'b0, '0, '0);
      test_busy_start();
      test_abort();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
